key_debounce_array: RTL and testbench

Multi-channel successor to the single-key debouncer. It filters NUM_KEYS raw mechanical key inputs and produces a clean level per key. It also produces one-cycle press/release events and long-press detection with optional auto-repeat. It sits between board key pins and the UI/control logic, so downstream blocks no longer need their own edge detectors or hold timers.

---
 rtl/key_debounce_array_pkg.sv | 19 +
 rtl/key_debounce_chan.sv | 120 ++++++++++++
 rtl/key_debounce_array.sv | 45 ++++
 tb/tb_key_debounce_array.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_array_pkg.sv
// Shared types for the key debouncer: hold-FSM state encoding and the
// per-channel output bundle handed from each channel to the array top.
package key_debounce_array_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } hold_state_e;

  typedef struct packed {
    logic level;
    logic press;
    logic rls;
    logic lng;
    logic rpt;
  } key_evt_t;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, stability filter, press/release edges
// and the long-press / auto-repeat hold FSM.
module key_debounce_chan
  import key_debounce_array_pkg::*;
#(
  parameter int ACTIVE_HIGH   = 1,
  parameter int STABLE_CYCLES = 20,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key,
  output key_evt_t evt
);

  localparam logic IDLE_RAW = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam bit   REP_EN   = (REPEAT_CYCLES != 0);

  logic [1:0] sync;
  logic       s;

  // Sync flops come out of reset at the idle raw level so no press is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{IDLE_RAW}};
    else        sync <= {sync[0], key};
  end

  assign s = (ACTIVE_HIGH != 0) ? sync[1] : ~sync[1];

  logic [CNT_W-1:0] stab_cnt;
  logic             level, prs_q, rls_q;
  logic             flip, press_ev, rel_ev;

  assign flip     = (s != level) && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign press_ev = flip & s;
  assign rel_ev   = flip & ~s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      level    <= 1'b0;
      prs_q    <= 1'b0;
      rls_q    <= 1'b0;
    end else begin
      prs_q <= press_ev;
      rls_q <= rel_ev;
      if (s == level) begin
        stab_cnt <= '0;
      end else if (flip) begin
        level    <= s;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
    end
  end

  hold_state_e      state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_n, rep_cnt, rep_n;
  logic             lng_q, lng_n, rpt_q, rpt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RELEASED;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      lng_q    <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      rep_cnt  <= rep_n;
      lng_q    <= lng_n;
      rpt_q    <= rpt_n;
    end
  end

  // Release is checked first so it suppresses a coincident long/repeat pulse.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    rep_n   = rep_cnt;
    lng_n   = 1'b0;
    rpt_n   = 1'b0;
    if (rel_ev) begin
      state_n = RELEASED;
      hold_n  = '0;
      rep_n   = '0;
    end else begin
      case (state)
        RELEASED: if (press_ev) begin
          state_n = HELD;
          hold_n  = CNT_W'(1);
        end
        HELD: if (hold_cnt >= CNT_W'(LONG_CYCLES - 1)) begin
          state_n = LONG_HELD;
          hold_n  = CNT_W'(LONG_CYCLES);
          rep_n   = '0;
          lng_n   = 1'b1;
        end else begin
          hold_n  = hold_cnt + CNT_W'(1);
        end
        LONG_HELD: if (REP_EN) begin
          if (rep_cnt >= CNT_W'(REPEAT_CYCLES - 1)) begin
            rep_n = '0;
            rpt_n = 1'b1;
          end else begin
            rep_n = rep_cnt + CNT_W'(1);
          end
        end
        default: state_n = RELEASED;
      endcase
    end
  end

  assign evt = '{level: level, press: prs_q, rls: rls_q, lng: lng_q, rpt: rpt_q};

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS independent debounced key channels with press/release/long/repeat
// event pulses, flattened onto per-event buses.
module key_debounce_array
  import key_debounce_array_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int ACTIVE_HIGH   = 1,
  parameter int STABLE_CYCLES = 20,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  key_evt_t [NUM_KEYS-1:0] evt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .ACTIVE_HIGH  (ACTIVE_HIGH),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .key  (key[i]),
      .evt  (evt[i])
    );
    assign key_level[i]   = evt[i].level;
    assign key_press[i]   = evt[i].press;
    assign key_release[i] = evt[i].rls;
    assign key_long[i]    = evt[i].lng;
    assign key_repeat[i]  = evt[i].rpt;
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array: expected pulses are queued with their
// cycle number and matched against every pulse the two DUTs emit.
module tb_key_debounce_array;

  typedef struct packed {
    int cyc;
    int dut;
    int ch;
    int kind;   // 0 press, 1 release, 2 long, 3 repeat
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_a, key_b;
  logic [3:0] a_lvl, a_prs, a_rel, a_lng, a_rpt;
  logic [3:0] b_lvl, b_prs, b_rel, b_lng, b_rpt;
  logic [3:0] pul [2][4];

  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_debounce_array #(
    .NUM_KEYS(4), .ACTIVE_HIGH(1), .STABLE_CYCLES(4),
    .LONG_CYCLES(20), .REPEAT_CYCLES(5), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .key(key_a),
    .key_level(a_lvl), .key_press(a_prs), .key_release(a_rel),
    .key_long(a_lng), .key_repeat(a_rpt)
  );

  key_debounce_array #(
    .NUM_KEYS(4), .ACTIVE_HIGH(0), .STABLE_CYCLES(4),
    .LONG_CYCLES(20), .REPEAT_CYCLES(0), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .key(key_b),
    .key_level(b_lvl), .key_press(b_prs), .key_release(b_rel),
    .key_long(b_lng), .key_repeat(b_rpt)
  );

  always_comb begin
    pul[0][0] = a_prs; pul[0][1] = a_rel; pul[0][2] = a_lng; pul[0][3] = a_rpt;
    pul[1][0] = b_prs; pul[1][1] = b_rel; pul[1][2] = b_lng; pul[1][3] = b_rpt;
  end

  task automatic push(input int c, input int d, input int ch, input int k);
    exp_q.push_back('{cyc: c, dut: d, ch: ch, kind: k});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every observed pulse must match the head of the queue (same-cycle pulses
  // are scanned dut, kind, channel ascending; pushes follow that order).
  task automatic scan_events();
    ev_t obs, ex;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        for (int ch = 0; ch < 4; ch++)
          if (pul[d][k][ch] === 1'b1) begin
            obs = '{cyc: cyc, dut: d, ch: ch, kind: k};
            if (exp_q.size() == 0) ex = '{cyc: -1, dut: -1, ch: -1, kind: -1};
            else                   ex = exp_q.pop_front();
            compared++;
            assert (obs === ex) else begin
              mismatched++;
              $error("FAIL event: observed cyc=%0d dut=%0d ch=%0d kind=%0d expected cyc=%0d dut=%0d ch=%0d kind=%0d",
                     obs.cyc, obs.dut, obs.ch, obs.kind, ex.cyc, ex.dut, ex.ch, ex.kind);
            end
          end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      scan_events();
    end
  endtask

  int c, p, q;

  initial begin
    rst_n = 1'b0;
    key_a = 4'h0;
    key_b = 4'hF;
    ticks(3);
    chk("rst_a_level", 32'(a_lvl), 0);
    chk("rst_a_pulses", 32'({a_prs, a_rel, a_lng, a_rpt}), 0);
    chk("rst_b_level", 32'(b_lvl), 0);
    rst_n = 1'b1;
    ticks(12);
    chk("idle_b_level", 32'(b_lvl), 0);
    chk("idle_a_level", 32'(a_lvl), 0);

    // Bounce on key[0]: only the final 0->1 survives
    c = cyc;
    push(c + 18, 0, 0, 0);
    push(c + 26, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      key_a[0] = (i % 2 == 0);
      ticks(1);
      if (i == 6) chk("bounce_level", 32'(a_lvl[0]), 0);
    end
    key_a[0] = 1'b1;
    ticks(5);
    chk("bounce_pre_press", 32'(a_lvl[0]), 0);
    ticks(1);
    chk("bounce_post_press", 32'(a_lvl[0]), 1);
    ticks(2);
    key_a[0] = 1'b0;
    ticks(5);
    chk("bounce_pre_rel", 32'(a_lvl[0]), 1);
    ticks(1);
    chk("bounce_post_rel", 32'(a_lvl[0]), 0);
    ticks(4);

    // Glitch of STABLE_CYCLES-1 rejected, STABLE_CYCLES accepted
    key_a[1] = 1'b1;
    ticks(3);
    key_a[1] = 1'b0;
    ticks(10);
    chk("glitch3_level", 32'(a_lvl[1]), 0);
    c = cyc;
    push(c + 6, 0, 1, 0);
    push(c + 10, 0, 1, 1);
    key_a[1] = 1'b1;
    ticks(4);
    key_a[1] = 1'b0;
    ticks(2);
    chk("glitch4_level", 32'(a_lvl[1]), 1);
    ticks(4);
    chk("glitch4_rel_level", 32'(a_lvl[1]), 0);
    ticks(4);

    // Long press with repeats; release lands on a would-be repeat edge
    c = cyc;
    p = c + 6;
    push(p, 0, 2, 0);
    push(p + 19, 0, 2, 2);
    for (int r = 24; r <= 54; r += 5) push(p + r, 0, 2, 3);
    push(p + 59, 0, 2, 1);
    key_a[2] = 1'b1;
    ticks(59);
    key_a[2] = 1'b0;
    ticks(6);
    chk("long_rel_level", 32'(a_lvl[2]), 0);
    ticks(10);

    // Simultaneous press on keys 0 and 3
    c = cyc;
    push(c + 6, 0, 0, 0);
    push(c + 6, 0, 3, 0);
    push(c + 16, 0, 3, 1);
    push(c + 20, 0, 0, 1);
    key_a[0] = 1'b1;
    key_a[3] = 1'b1;
    ticks(10);
    key_a[3] = 1'b0;
    ticks(4);
    key_a[0] = 1'b0;
    ticks(3);
    chk("simul_level", 32'(a_lvl), 32'h1);
    ticks(3);
    chk("simul_rel_level", 32'(a_lvl), 0);
    ticks(4);

    // Asynchronous reset while key[2] is in LONG_HELD
    c = cyc;
    push(c + 6, 0, 2, 0);
    push(c + 25, 0, 2, 2);
    key_a[2] = 1'b1;
    ticks(27);
    chk("hold_level", 32'(a_lvl), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(a_lvl), 0);
    chk("async_rst_pulses", 32'({a_prs, a_rel, a_lng, a_rpt}), 0);
    chk("async_rst_b_level", 32'(b_lvl), 0);
    ticks(3);
    q = cyc;
    push(q + 6, 0, 2, 0);
    rst_n = 1'b1;
    ticks(5);
    chk("rearm_pre_level", 32'(a_lvl[2]), 0);
    ticks(1);
    chk("rearm_level", 32'(a_lvl[2]), 1);
    ticks(4);
    key_a[2] = 1'b0;
    push(q + 16, 0, 2, 1);
    ticks(8);

    // Active-low DUT, repeat disabled
    c = cyc;
    push(c + 6, 1, 1, 0);
    push(c + 25, 1, 1, 2);
    push(c + 36, 1, 1, 1);
    key_b[1] = 1'b0;
    ticks(6);
    chk("b_press_level", 32'(b_lvl), 32'h2);
    ticks(24);
    key_b[1] = 1'b1;
    ticks(6);
    chk("b_rel_level", 32'(b_lvl), 0);
    ticks(20);

    chk("pending_events", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
